// File: rtl/pc_seq_if.sv
// pc_seq_if: control-unit <-> pc_sequencer bundle: fetch commit, redirect handshake with target operands, PC outputs.
interface pc_seq_if #(
    parameter int ADDR_W  = 32,
    parameter int JADDR_W = 26,
    parameter int IMM_W   = 16
);
    logic               pc_wr;
    logic               redir_valid;
    logic               redir_ready;
    logic [1:0]         redir_sel;
    logic               redir_link;
    logic [IMM_W-1:0]   imm;
    logic [JADDR_W-1:0] jaddr;
    logic [ADDR_W-1:0]  rs_data;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               pending;
    logic               misalign;
    modport master (
        output pc_wr, redir_valid, redir_sel, redir_link, imm, jaddr, rs_data,
        input  redir_ready, pc, pc_plus4, pending, misalign
    );
    modport slave (
        input  pc_wr, redir_valid, redir_sel, redir_link, imm, jaddr, rs_data,
        output redir_ready, pc, pc_plus4, pending, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with +4 fetch advance and a one-deep redirect buffer (branch/jump/register/return).
// Defining PCSEQ_RAS_EN adds a RAS_DEPTH-entry circular return-address stack for sel=11.
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                JADDR_W   = 26,
    parameter int                IMM_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    pc_seq_if.slave bus
);
    typedef enum logic {EMPTY, HELD} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_q, pc4_q, pc_n, tgt_q, target, reg_tgt, br_tgt, jmp_tgt, ret_tgt;
    logic              ready, xfer, load_tgt, ret_hit, reg_sel, mis_q, mis_n;
    assign reg_tgt = {bus.rs_data[ADDR_W-1:2], 2'b00};
    assign br_tgt  = pc_q + (ADDR_W'($signed(bus.imm)) << 2);
    assign jmp_tgt = {pc_q[ADDR_W-1:JADDR_W+2], bus.jaddr, 2'b00};
`ifdef PCSEQ_RAS_EN
    localparam int RW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [RW-1:0]     top, top_inc, top_dec;
    logic [CW-1:0]     cnt;
    logic              push, pop;
    assign push    = xfer && bus.redir_link && (bus.redir_sel == 2'b01 || bus.redir_sel == 2'b10);
    assign pop     = xfer && bus.redir_sel == 2'b11 && ret_hit;
    assign top_inc = top == RW'(RAS_DEPTH - 1) ? '0 : top + RW'(1);
    assign top_dec = top == '0 ? RW'(RAS_DEPTH - 1) : top - RW'(1);
    assign ret_hit = cnt != '0;
    assign ret_tgt = ras[top];
    // Full stack keeps advancing top, so the oldest entry is silently overwritten.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            top <= '0;
            cnt <= '0;
        end else if (push) begin
            top <= top_inc;
            cnt <= cnt == CW'(RAS_DEPTH) ? cnt : cnt + CW'(1);
        end else if (pop) begin
            top <= top_dec;
            cnt <= cnt - CW'(1);
        end
    always_ff @(posedge clk)
        if (push) ras[top_inc] <= pc_q;
`else
    localparam int unused_depth = RAS_DEPTH;
    logic unused_link;
    assign unused_link = bus.redir_link;
    assign ret_hit     = 1'b0;
    assign ret_tgt     = reg_tgt;
`endif
    assign reg_sel = bus.redir_sel[1] && !(bus.redir_sel[0] && ret_hit);
    assign target  = bus.redir_sel == 2'b00 ? br_tgt :
                     bus.redir_sel == 2'b01 ? jmp_tgt :
                     reg_sel ? reg_tgt : ret_tgt;
    assign ready   = state == EMPTY || bus.pc_wr;
    assign xfer    = bus.redir_valid && ready;
    // A held redirect always drains first; a new one is only bypassed straight into pc when nothing is held.
    always_comb begin
        load_tgt = xfer && (state == HELD || !bus.pc_wr);
        state_n  = load_tgt ? HELD : bus.pc_wr ? EMPTY : state;
        pc_n     = !bus.pc_wr ? pc_q : state == HELD ? tgt_q : xfer ? target : pc_q + ADDR_W'(4);
        mis_n    = xfer && reg_sel && bus.rs_data[1:0] != 2'b00;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= EMPTY;
        else     state <= state_n;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc_q  <= RESET_PC;
            pc4_q <= RESET_PC + ADDR_W'(4);
            tgt_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_n;
            pc4_q <= pc_n + ADDR_W'(4);
            mis_q <= mis_n;
            if (load_tgt) tgt_q <= target;
        end
    assign bus.redir_ready = ready;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc4_q;
    assign bus.pending     = state == HELD;
    assign bus.misalign    = mis_q;
endmodule
